// File: rtl/add_pipe_nbit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : add_pipe_nbit                                                 |
// | Purpose  : Pipelined WIDTH-bit adder/subtractor, one CW-bit ripple chunk |
// |            per stage, valid/ready with a global stall enable.            |
// | Options  : ADD_PIPE_FLAGS_EN adds zero/neg/ovf result flags.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module add_pipe_nbit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADD_PIPE_FLAGS_EN
    output logic             zero,
    output logic             neg,
    output logic             ovf,
`endif
    output logic             co
);

    localparam int CW = WIDTH / STAGES;

    logic w_en;

    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    // Stage k holds the finished low chunks plus the not-yet-used upper operand bits.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = k * CW;
            localparam int RW = WIDTH - LO;

            logic [RW-1:0]      w_a;
            logic [RW-1:0]      w_b;
            logic               w_c;
            logic               w_v;
            logic [CW:0]        w_chunk;
            logic [LO+CW-1:0]   w_sum_nxt;
            logic [LO+CW-1:0]   r_sum;
            logic               r_valid;
            logic               r_c;

            if (k == 0) begin : g_first
                assign w_a       = X;
                assign w_b       = sub ? ~Y : Y;
                assign w_c       = ci ^ sub;
                assign w_v       = in_valid;
                assign w_sum_nxt = w_chunk[CW-1:0];
            end else begin : g_next
                assign w_a       = g_stage[k-1].g_skew.r_a;
                assign w_b       = g_stage[k-1].g_skew.r_b;
                assign w_c       = g_stage[k-1].r_c;
                assign w_v       = g_stage[k-1].r_valid;
                assign w_sum_nxt = {w_chunk[CW-1:0], g_stage[k-1].r_sum};
            end

            assign w_chunk = {1'b0, w_a[CW-1:0]} + {1'b0, w_b[CW-1:0]} + {{CW{1'b0}}, w_c};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_c     <= 1'b0;
                    r_sum   <= '0;
                end else if (w_en) begin
                    r_valid <= w_v;
                    r_c     <= w_chunk[CW];
                    r_sum   <= w_sum_nxt;
                end
            end

            if (k < STAGES - 1) begin : g_skew
                logic [RW-CW-1:0] r_a;
                logic [RW-CW-1:0] r_b;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_en) begin
                        r_a <= w_a[RW-1:CW];
                        r_b <= w_b[RW-1:CW];
                    end
                end
            end

`ifdef ADD_PIPE_FLAGS_EN
            // In the last stage w_a/w_b are exactly the top chunk, so bit CW-1 is the operand sign.
            if (k == STAGES - 1) begin : g_flags
                logic r_zero;
                logic r_neg;
                logic r_ovf;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_zero <= 1'b0;
                        r_neg  <= 1'b0;
                        r_ovf  <= 1'b0;
                    end else if (w_en) begin
                        r_zero <= ~|w_sum_nxt;
                        r_neg  <= w_chunk[CW-1];
                        r_ovf  <= (w_a[CW-1] == w_b[CW-1]) && (w_chunk[CW-1] != w_a[CW-1]);
                    end
                end
            end
`endif
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign co        = g_stage[STAGES-1].r_c;

`ifdef ADD_PIPE_FLAGS_EN
    assign zero = g_stage[STAGES-1].g_flags.r_zero;
    assign neg  = g_stage[STAGES-1].g_flags.r_neg;
    assign ovf  = g_stage[STAGES-1].g_flags.r_ovf;
`endif

endmodule
`default_nettype wire
